// File: rtl/common.sv
// Basic scalar types shared across the execute stage.
package common;
    typedef logic [63:0] u64;
    typedef logic        u1;
endpackage

// File: rtl/pipes.sv
// Pipeline-wide enums and constants used by the execute-stage units.
package pipes;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    localparam int unsigned DIV_ITER_D = 64;
    localparam int unsigned DIV_ITER_W = 32;
endpackage

// File: rtl/div_sign_fix.sv
// Operand conditioning for the divider: magnitudes and negate flags on entry,
// result negation and W-form sign extension on exit.
module div_sign_fix
    import common::*;
(
    input  u64 i_a,
    input  u64 i_b,
    input  u1  i_sign,
    input  u1  i_cut,
    output u64 o_a_ext,
    output u64 o_b_ext,
    output u64 o_a_mag,
    output u64 o_b_mag,
    output u1  o_neg_q,
    output u1  o_neg_r,
    input  u64 i_q,
    input  u64 i_r,
    input  u1  i_neg_q,
    input  u1  i_neg_r,
    input  u1  i_rem_sel,
    input  u1  i_cut_res,
    output u64 o_res
);
    u64 w_a_ext;
    u64 w_b_ext;
    u1  w_a_neg;
    u1  w_b_neg;
    u64 w_sel;
    u1  w_neg;
    u64 w_val;

    assign w_a_ext = i_cut ? (i_sign ? {{32{i_a[31]}}, i_a[31:0]} : {32'b0, i_a[31:0]}) : i_a;
    assign w_b_ext = i_cut ? (i_sign ? {{32{i_b[31]}}, i_b[31:0]} : {32'b0, i_b[31:0]}) : i_b;

    assign w_a_neg = i_sign & w_a_ext[63];
    assign w_b_neg = i_sign & w_b_ext[63];

    assign o_a_ext = w_a_ext;
    assign o_b_ext = w_b_ext;
    assign o_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    assign o_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    assign o_neg_q = w_a_neg ^ w_b_neg;
    assign o_neg_r = w_a_neg;

    // Only the low 32 bits matter for W results, so negating the full word is safe.
    assign w_sel = i_rem_sel ? i_r : i_q;
    assign w_neg = i_rem_sel ? i_neg_r : i_neg_q;
    assign w_val = w_neg ? -w_sel : w_sel;
    assign o_res = i_cut_res ? {{32{w_val[31]}}, w_val[31:0]} : w_val;
endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle RV64M divide/remainder unit (restoring radix-2, one bit per cycle)
// acting as the responder to execute's stall handshake.
module iterative_divider
    import common::*;
    import pipes::*;
#(
    parameter int unsigned XLEN = 64
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sign,
    input  logic            cut,
    input  logic            rem_sel,
    input  logic            flush,
    output logic            e_wait,
    output logic            done,
    output logic [XLEN-1:0] c
);
    div_state_t r_state;
    div_state_t w_next;

    logic [6:0] r_cnt;
    u64         r_q;
    u64         r_rem;
    u64         r_div;
    u1          r_neg_q;
    u1          r_neg_r;
    u1          r_rem_sel;
    u1          r_cut;

    u64 w_a_ext;
    u64 w_b_ext;
    u64 w_a_mag;
    u64 w_b_mag;
    u1  w_neg_q;
    u1  w_neg_r;
    u64 w_res;

    u1           w_accept;
    u1           w_div_zero;
    u1           w_ovf;
    u1           w_special;
    u64          w_spec_q;
    u64          w_spec_r;
    u1           w_qmsb;
    logic [64:0] w_rem_shift;
    u1           w_ge;
    u64          w_rem_next;
    u64          w_q_next;

    div_sign_fix u_sign_fix (
        .i_a       (a),
        .i_b       (b),
        .i_sign    (sign),
        .i_cut     (cut),
        .o_a_ext   (w_a_ext),
        .o_b_ext   (w_b_ext),
        .o_a_mag   (w_a_mag),
        .o_b_mag   (w_b_mag),
        .o_neg_q   (w_neg_q),
        .o_neg_r   (w_neg_r),
        .i_q       (r_q),
        .i_r       (r_rem),
        .i_neg_q   (r_neg_q),
        .i_neg_r   (r_neg_r),
        .i_rem_sel (r_rem_sel),
        .i_cut_res (r_cut),
        .o_res     (w_res)
    );

    assign w_accept   = (r_state == IDLE) & start & ~flush;
    assign w_div_zero = (w_b_ext == '0);
    assign w_ovf      = sign & (w_b_ext == '1) &
                        (cut ? (w_a_ext == 64'hFFFF_FFFF_8000_0000)
                             : (w_a_ext == 64'h8000_0000_0000_0000));
    assign w_special  = w_div_zero | w_ovf;
    // Special results are stored already final, with both negate flags cleared.
    assign w_spec_q   = w_div_zero ? '1 : w_a_ext;
    assign w_spec_r   = w_div_zero ? w_a_ext : '0;

    assign w_qmsb      = r_cut ? r_q[DIV_ITER_W-1] : r_q[DIV_ITER_D-1];
    assign w_rem_shift = {r_rem, w_qmsb};
    assign w_ge        = (w_rem_shift >= {1'b0, r_div});
    assign w_rem_next  = w_ge ? (w_rem_shift[63:0] - r_div) : w_rem_shift[63:0];
    assign w_q_next    = {r_q[62:0], w_ge};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        e_wait = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                e_wait = start & ~flush;
                if (w_accept) begin
                    w_next = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                e_wait = 1'b1;
                if (flush) begin
                    w_next = IDLE;
                end else if (r_cnt == 7'd1) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = ~flush;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        c = done ? w_res : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_q       <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rem_sel <= 1'b0;
            r_cut     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rem_sel <= rem_sel;
                        r_cut     <= cut;
                        r_div     <= w_b_mag;
                        if (w_special) begin
                            r_q     <= w_spec_q;
                            r_rem   <= w_spec_r;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_q     <= w_a_mag;
                            r_rem   <= '0;
                            r_neg_q <= w_neg_q;
                            r_neg_r <= w_neg_r;
                            r_cnt   <= cut ? 7'(DIV_ITER_W) : 7'(DIV_ITER_D);
                        end
                    end
                end
                CALC: begin
                    r_q   <= w_q_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - 7'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider with a per-cycle arithmetic reference model.
module tb_iterative_divider;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic        cut = 1'b0;
    logic        rem_sel = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        e_wait;
    logic        done;
    logic [63:0] c;

    int unsigned total = 0;
    int unsigned bad = 0;

    bit          m_busy = 1'b0;
    int unsigned m_cnt = 0;
    logic [63:0] m_c = '0;

    always #5 clk = ~clk;

    iterative_divider #(.XLEN(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .sign    (sign),
        .cut     (cut),
        .rem_sel (rem_sel),
        .flush   (flush),
        .e_wait  (e_wait),
        .done    (done),
        .c       (c)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    // RISC-V M-extension result rules in plain arithmetic.
    function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input bit s, input bit w, input bit r);
        logic [31:0]        x32, y32, r32;
        logic signed [31:0] sx32, sy32;
        logic signed [63:0] sx, sy;
        logic [63:0]        res;
        if (w) begin
            x32 = x[31:0];
            y32 = y[31:0];
            sx32 = x32;
            sy32 = y32;
            if (y32 == 32'd0)
                r32 = r ? x32 : 32'hFFFF_FFFF;
            else if (s && x32 == 32'h8000_0000 && y32 == 32'hFFFF_FFFF)
                r32 = r ? 32'd0 : x32;
            else if (s)
                r32 = r ? 32'(sx32 % sy32) : 32'(sx32 / sy32);
            else
                r32 = r ? (x32 % y32) : (x32 / y32);
            res = {{32{r32[31]}}, r32};
        end else begin
            sx = x;
            sy = y;
            if (y == 64'd0)
                res = r ? x : '1;
            else if (s && x == 64'h8000_0000_0000_0000 && y == '1)
                res = r ? 64'd0 : x;
            else if (s)
                res = r ? 64'(sx % sy) : 64'(sx / sy);
            else
                res = r ? (x % y) : (x / y);
        end
        return res;
    endfunction

    function automatic int unsigned lat_of(input logic [63:0] x, input logic [63:0] y,
                                           input bit s, input bit w);
        if (w) begin
            if (y[31:0] == 32'd0 || (s && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF))
                return 1;
            return 33;
        end
        if (y == 64'd0 || (s && x == 64'h8000_0000_0000_0000 && y == '1))
            return 1;
        return 65;
    endfunction

    // Per-cycle comparison against the reference model; model advances at each negedge.
    always @(negedge clk) begin
        if (!reset) begin
            m_busy = 1'b0;
            chk("cmp_rst_done", 64'(done), 64'd0);
            chk("cmp_rst_c", c, 64'd0);
            chk("cmp_rst_wait", 64'(e_wait), 64'(start && !flush));
        end else if (m_busy) begin
            chk("cmp_done", 64'(done), 64'(m_cnt == 0 && !flush));
            chk("cmp_c", c, (m_cnt == 0 && !flush) ? m_c : 64'd0);
            chk("cmp_wait", 64'(e_wait), 64'(m_cnt != 0));
            if (flush || m_cnt == 0) m_busy = 1'b0;
            else m_cnt--;
        end else begin
            chk("cmp_idle_done", 64'(done), 64'd0);
            chk("cmp_idle_c", c, 64'd0);
            chk("cmp_idle_wait", 64'(e_wait), 64'(start && !flush));
            if (start && !flush) begin
                m_busy = 1'b1;
                m_c    = model(a, b, sign, cut, rem_sel);
                m_cnt  = lat_of(a, b, sign, cut) - 1;
            end
        end
    end

    // Leaves start high so a following call lands in the cycle after DONE.
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tbv, input bit ts,
                          input bit tw, input bit tr, input logic [63:0] want,
                          input int unsigned want_wait, input string nm);
        int unsigned nw;
        bit          got;
        logic [63:0] gc;
        nw = 0;
        got = 1'b0;
        gc = '0;
        @(posedge clk);
        #1;
        a = ta;
        b = tbv;
        sign = ts;
        cut = tw;
        rem_sel = tr;
        start = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (e_wait === 1'b1) nw++;
            if (done === 1'b1) begin
                got = 1'b1;
                gc = c;
            end
        end
        chk({nm, "_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk(nm, gc, want);
            chk({nm, "_wait"}, 64'(nw), 64'(want_wait));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw;
        #1;
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_c", c, 64'd0);
        chk("reset_wait", 64'(e_wait), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        chk("pin_divu", model(64'd100, 64'd7, 1'b0, 1'b0, 1'b0), 64'd14);
        chk("pin_div_neg", model(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b0, 1'b0), 64'hFFFF_FFFF_FFFF_FFF2);
        chk("pin_divw_ovf", model(64'h8000_0000, '1, 1'b1, 1'b1, 1'b0), 64'hFFFF_FFFF_8000_0000);
        chk("pin_rem_zero", model(64'd5, 64'd0, 1'b1, 1'b0, 1'b1), 64'd5);

        run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 65, "divu");
        run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 64'd2, 65, "remu");
        run_op(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 65, "div_neg");
        run_op(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 65, "rem_neg");
        run_op(64'h0000_0000_8000_0000, '1, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");
        run_op(64'h0000_0000_8000_0000, '1, 1'b1, 1'b1, 1'b1, 64'd0, 1, "remw_ovf");
        run_op(64'd5, 64'd0, 1'b1, 1'b0, 1'b0, '1, 1, "div_zero");
        run_op(64'd5, 64'd0, 1'b1, 1'b0, 1'b1, 64'd5, 1, "rem_zero");
        run_op(64'h8000_0000_0000_0000, 64'd2, 1'b1, 1'b0, 1'b0, 64'hC000_0000_0000_0000, 65, "div_minneg");
        run_op(64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw_neg");
        @(posedge clk);
        #1 start = 1'b0;

        @(posedge clk);
        #1;
        a = 64'd50;
        b = 64'd5;
        sign = 1'b0;
        cut = 1'b0;
        rem_sel = 1'b0;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_wait", 64'(e_wait), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_nodone", 64'(done), 64'd0);
        chk("idle_flush_nowait", 64'(e_wait), 64'd0);

        saw = 1'b0;
        @(posedge clk);
        #1;
        a = 64'd1000;
        b = 64'd3;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw = 1'b1;
            @(posedge clk);
        end
        #1;
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        if (done === 1'b1) saw = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        if (done === 1'b1) saw = 1'b1;
        chk("flush_no_done", 64'(saw), 64'd0);
        run_op(64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 64'd3, 65, "post_flush");
        @(posedge clk);
        #1 start = 1'b0;

        @(posedge clk);
        #1;
        a = 64'd123456789;
        b = 64'd10;
        start = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        #1;
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_c", c, 64'd0);
        chk("midrst_wait", 64'(e_wait), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run_op(64'h0000_0000_FFFF_FFFF, 64'd16, 1'b0, 1'b1, 1'b1, 64'd15, 33, "remuw");
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
